// File: rtl/flappy_pkg.sv
// flappy_pkg: shared definitions for the pipe scheduler and its neighbours.
//   - sched_state_t : scheduler FSM encoding (IDLE, LOAD, RUN, HOLD)
//   - LFSR_SEED     : reset value of the pipe-height LFSR
//   - SCREEN_W/H    : screen size in pixels
//   - X_LOAD_BASE   : x of the first pipe when a run is loaded
//   - Y_BASE, GAP_H : top of the gap range and gap height, shared with the
//                     collision and display blocks
//   - sat_inc4      : 4-bit saturating increment used for the score
package flappy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } sched_state_t;

  localparam logic [7:0] LFSR_SEED   = 8'hA5;
  localparam logic [9:0] SCREEN_W    = 10'd640;
  localparam logic [9:0] SCREEN_H    = 10'd480;
  localparam logic [9:0] X_LOAD_BASE = 10'd320;
  localparam logic [9:0] Y_BASE      = 10'd40;
  localparam logic [9:0] GAP_H       = 10'd100;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/pipe_lfsr.sv
// pipe_lfsr: 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1, free running.
// The seed is loaded by the asynchronous reset; the register can never reach
// zero because the polynomial is maximal and the seed is non-zero.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, loads SEED
//   value - current LFSR state, advances every cycle
module pipe_lfsr
  import flappy_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] value
);

  // Right-shifting Galois form: the bit shifted out toggles the tap mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value <= SEED;
    else        value <= {1'b0, value[7:1]} ^ (value[0] ? 8'hB8 : 8'h00);
  end

endmodule

// File: rtl/pipe_scheduler.sv
// pipe_scheduler: ring of NUM_PIPES pipe slots that scroll left on each Tick,
// respawn behind their predecessor, and score when the bird passes them.
// Optional feature macro: PIPE_SPEEDUP_EN (speed grows by Score[3:2]).
// Ports:
//   Clk, reset          - clock; asynchronous active-low reset whose release
//                         is synchronized (logic first acts on 2nd edge)
//   Start               - level, begins a run from IDLE
//   Tick                - frame strobe, scrolls the pipes while in RUN
//   Freeze              - level from collision logic, halts the run (HOLD)
//   Bird_X              - bird left x
//   Rd_Index            - display read-port slot select
//   Pipe_Index          - slot currently in scope for collision/scoring
//   X_Edge, Y_Edge      - left edge and gap-top edge of the in-scope slot
//   Rd_X, Rd_Y          - edges of slot Rd_Index (combinational)
//   Score, Score_Pulse  - saturating score and one-cycle increment strobe
//   Running             - high in RUN
//   dbg_state           - current FSM state
// Start, Tick and Freeze are plain level/strobe inputs sampled on every
// rising edge; there is no valid/ready handshake on this block.
module pipe_scheduler
  import flappy_pkg::*;
#(
  parameter int unsigned NUM_PIPES = 4,
  parameter logic [9:0]  SPACING   = 10'd160,
  parameter logic [9:0]  PIPE_W    = 10'd80,
  parameter logic [9:0]  SPEED     = 10'd2,
  localparam int         IW        = $clog2(NUM_PIPES)
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          Start,
  input  logic          Tick,
  input  logic          Freeze,
  input  logic [9:0]    Bird_X,
  input  logic [IW-1:0] Rd_Index,
  output logic [IW-1:0] Pipe_Index,
  output logic [9:0]    X_Edge,
  output logic [9:0]    Y_Edge,
  output logic [9:0]    Rd_X,
  output logic [9:0]    Rd_Y,
  output logic [3:0]    Score,
  output logic          Score_Pulse,
  output logic          Running,
  output sched_state_t  dbg_state
);

  sched_state_t  state, state_nxt;
  logic          rst_q;
  logic [IW-1:0] load_cnt;
  logic [9:0]    x_q [NUM_PIPES];
  logic [9:0]    y_q [NUM_PIPES];
  logic [7:0]    lfsr;
  logic [9:0]    spd;
  logic [9:0]    new_y;
  logic [10:0]   right_edge;
  logic          score_hit;
  logic          scroll;

  // Assertion is immediate (async clear of rst_q); release takes one edge,
  // so the rest of the design first updates on the second edge.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) rst_q <= 1'b0;
    else        rst_q <= 1'b1;
  end

  pipe_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (Clk),
    .rst_n (rst_q),
    .value (lfsr)
  );

`ifdef PIPE_SPEEDUP_EN
  assign spd = SPEED + {8'b0, Score[3:2]};
`else
  assign spd = SPEED;
`endif

  assign new_y      = Y_BASE + {2'b0, lfsr};
  assign X_Edge     = x_q[Pipe_Index];
  assign Y_Edge     = y_q[Pipe_Index];
  assign Rd_X       = x_q[Rd_Index];
  assign Rd_Y       = y_q[Rd_Index];
  assign Running    = (state == ST_RUN);
  assign dbg_state  = state;

  // 11-bit sum so a pipe near the right edge cannot wrap to a small value.
  assign right_edge = {1'b0, X_Edge} + {1'b0, PIPE_W};
  assign score_hit  = (state == ST_RUN) && !Freeze && (right_edge < {1'b0, Bird_X});
  // Freeze wins over Tick in the same cycle.
  assign scroll     = (state == ST_RUN) && Tick && !Freeze;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (Start) state_nxt = ST_LOAD;
      ST_LOAD: if (load_cnt == IW'(NUM_PIPES - 1)) state_nxt = ST_RUN;
      ST_RUN:  if (Freeze) state_nxt = ST_HOLD;
      ST_HOLD: if (!Freeze && !Start) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge rst_q) begin
    if (!rst_q) begin
      state       <= ST_IDLE;
      load_cnt    <= '0;
      Score       <= '0;
      Score_Pulse <= 1'b0;
      Pipe_Index  <= '0;
    end else begin
      state       <= state_nxt;
      Score_Pulse <= score_hit;
      if (state == ST_IDLE && Start) begin
        load_cnt   <= '0;
        Score      <= '0;
        Pipe_Index <= '0;
      end else if (state == ST_LOAD) begin
        load_cnt <= load_cnt + 1'b1;
      end
      if (score_hit) begin
        Score      <= sat_inc4(Score);
        Pipe_Index <= Pipe_Index + 1'b1;
      end
    end
  end

  // Slot ring. Respawn reads the predecessor's pre-Tick x, so every slot
  // sees the same snapshot regardless of update order.
  always_ff @(posedge Clk or negedge rst_q) begin
    if (!rst_q) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else if (state == ST_LOAD) begin
      x_q[load_cnt] <= X_LOAD_BASE + SPACING * 10'(load_cnt);
      y_q[load_cnt] <= new_y;
    end else if (scroll) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        if (x_q[i] < spd) begin
          x_q[i] <= x_q[IW'(i - 1)] + SPACING;
          y_q[i] <= new_y;
        end else begin
          x_q[i] <= x_q[i] - spd;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_scheduler.sv
// tb_pipe_scheduler: directed and randomized checks of pipe_scheduler against
// a behavioural reference model of the pipe ring, score and run phases.
module tb_pipe_scheduler;
  import flappy_pkg::*;

  localparam int MD_IDLE = 0;
  localparam int MD_LOAD = 1;
  localparam int MD_RUN  = 2;
  localparam int MD_HOLD = 3;

  logic         Clk;
  logic         reset;
  logic         Start, Tick, Freeze;
  logic [9:0]   Bird_X;
  logic [1:0]   Rd_Index;
  logic [1:0]   Pipe_Index;
  logic [9:0]   X_Edge, Y_Edge, Rd_X, Rd_Y;
  logic [3:0]   Score;
  logic         Score_Pulse, Running;
  sched_state_t dbg_state;

  int checks   = 0;
  int failures = 0;

  pipe_scheduler dut (
    .Clk         (Clk),
    .reset       (reset),
    .Start       (Start),
    .Tick        (Tick),
    .Freeze      (Freeze),
    .Bird_X      (Bird_X),
    .Rd_Index    (Rd_Index),
    .Pipe_Index  (Pipe_Index),
    .X_Edge      (X_Edge),
    .Y_Edge      (Y_Edge),
    .Rd_X        (Rd_X),
    .Rd_Y        (Rd_Y),
    .Score       (Score),
    .Score_Pulse (Score_Pulse),
    .Running     (Running),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  int         m_mode, m_cnt, m_score, m_idx, m_rel, m_spd;
  bit         m_pulse, m_hit;
  bit [7:0]   m_lfsr;
  int         m_x [4];
  int         m_y [4];
  int         m_nx [4];
  int         m_ny [4];

  always @(posedge Clk or negedge reset) begin
    if (!reset) begin
      m_mode = MD_IDLE; m_cnt = 0; m_score = 0; m_idx = 0;
      m_pulse = 1'b0; m_lfsr = 8'hA5; m_rel = 0;
      for (int i = 0; i < 4; i++) begin m_x[i] = 0; m_y[i] = 0; end
    end else if (m_rel == 0) begin
      m_rel = 1;  // first edge after release: design still held in reset
    end else begin
`ifdef PIPE_SPEEDUP_EN
      m_spd = 2 + ((m_score / 4) % 4);
`else
      m_spd = 2;
`endif
      m_hit   = (m_mode == MD_RUN) && !Freeze && ((m_x[m_idx] + 80) < int'(Bird_X));
      m_pulse = m_hit;
      case (m_mode)
        MD_IDLE: if (Start) begin
          m_mode = MD_LOAD; m_cnt = 0; m_score = 0; m_idx = 0;
        end
        MD_LOAD: begin
          m_x[m_cnt] = 320 + m_cnt * 160;
          m_y[m_cnt] = 40 + int'(m_lfsr);
          m_cnt++;
          if (m_cnt == 4) m_mode = MD_RUN;
        end
        MD_RUN: begin
          if (Freeze) m_mode = MD_HOLD;
          else begin
            if (Tick) begin
              for (int i = 0; i < 4; i++) begin
                if (m_x[i] < m_spd) begin
                  m_nx[i] = (m_x[(i + 3) % 4] + 160) % 1024;
                  m_ny[i] = 40 + int'(m_lfsr);
                end else begin
                  m_nx[i] = m_x[i] - m_spd;
                  m_ny[i] = m_y[i];
                end
              end
              for (int i = 0; i < 4; i++) begin m_x[i] = m_nx[i]; m_y[i] = m_ny[i]; end
            end
            if (m_hit) begin
              if (m_score < 15) m_score++;
              m_idx = (m_idx + 1) % 4;
            end
          end
        end
        default: if (!Freeze && !Start) m_mode = MD_IDLE;
      endcase
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ":running"},    32'(Running),     32'(m_mode == MD_RUN));
    check({tag, ":score"},      32'(Score),       32'(m_score));
    check({tag, ":pulse"},      32'(Score_Pulse), 32'(m_pulse));
    check({tag, ":pipe_index"}, 32'(Pipe_Index),  32'(m_idx));
    check({tag, ":x_edge"},     32'(X_Edge),      32'(m_x[m_idx]));
    check({tag, ":y_edge"},     32'(Y_Edge),      32'(m_y[m_idx]));
    check({tag, ":rd_x"},       32'(Rd_X),        32'(m_x[Rd_Index]));
    check({tag, ":rd_y"},       32'(Rd_Y),        32'(m_y[Rd_Index]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic start_run();
    Start = 1'b1;
    step();
    Start = 1'b0;
    repeat (4) begin step(); check_all("load_seq"); end
  endtask

  int exp_x [4];
  int exp_score;

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b0; Start = 1'b0; Tick = 1'b0; Freeze = 1'b0;
    Bird_X = '0; Rd_Index = '0;
    repeat (3) @(negedge Clk);
    check("rst_running", 32'(Running), 0);
    check("rst_score", 32'(Score), 0);
    check("rst_pulse", 32'(Score_Pulse), 0);
    check("rst_pipe_index", 32'(Pipe_Index), 0);
    check("rst_x_edge", 32'(X_Edge), 0);
    check("rst_rd_y", 32'(Rd_Y), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    reset = 1'b1;
    repeat (3) begin step(); check_all("idle"); end

    // Tick outside RUN is ignored.
    Tick = 1'b1;
    repeat (3) begin step(); check_all("idle_tick"); end
    Tick = 1'b0;

    // One-cycle Start: LOAD for 4 cycles, Running rises in cycle 6.
    Start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      Start = 1'b0;
      check("run_rise", 32'(Running), 32'(k >= 5));
      check_all("load");
    end
    for (int i = 0; i < 4; i++) begin
      Rd_Index = 2'(i);
      #1;
      check("load_x", 32'(Rd_X), 32'(320 + 160 * i));
      check("load_y", 32'(Rd_Y), 32'(m_y[i]));
    end

    // Bird at 500: slot0 (right edge 400) scores on the first RUN cycle.
    Bird_X = 10'd500;
    Rd_Index = 2'd1;
    step();
    check("first_score", 32'(Score), 1);
    check("first_pulse", 32'(Score_Pulse), 1);
    check("first_index", 32'(Pipe_Index), 1);
    check_all("bird500");

    for (int t = 1; t <= 160; t++) begin
      Tick = 1'b1;
      step();
      check_all("scroll");
      Tick = 1'b0;
      if ($urandom_range(0, 1) == 1) begin step(); check_all("scroll_gap"); end
    end
    Rd_Index = 2'd0;
    #1;
    check("slot0_at_zero", 32'(Rd_X), 0);
    check("score_after_160", 32'(Score), 3);
    check("index_after_160", 32'(Pipe_Index), 3);
    Tick = 1'b1;
    step();
    Tick = 1'b0;
    check("slot0_respawn_x", 32'(Rd_X), 640);
    check("slot1_after_161", 32'(X_Edge), 32'(m_x[m_idx]));
    check_all("respawn");

    // Randomized run.
    for (int n = 0; n < 500; n++) begin
      Tick     = 1'($urandom_range(0, 1));
      Bird_X   = 10'($urandom_range(0, 700));
      Rd_Index = 2'($urandom_range(0, 3));
      step();
      check_all("rand");
    end
    Tick = 1'b0;

    // Freeze and Tick together: no scroll, HOLD, frozen frame.
    for (int i = 0; i < 4; i++) exp_x[i] = m_x[i];
    exp_score = m_score;
    Freeze = 1'b1; Tick = 1'b1; Bird_X = 10'd1023;
    step();
    check("hold_state", 32'(dbg_state), 32'(ST_HOLD));
    check("hold_running", 32'(Running), 0);
    check("hold_score", 32'(Score), 32'(exp_score));
    check("hold_pulse", 32'(Score_Pulse), 0);
    for (int i = 0; i < 4; i++) begin
      Rd_Index = 2'(i);
      #1;
      check("hold_x", 32'(Rd_X), 32'(exp_x[i]));
    end
    repeat (2) begin step(); check_all("hold"); end
    Tick = 1'b0; Freeze = 1'b0; Start = 1'b1;
    step();
    check("hold_ignores_start", 32'(dbg_state), 32'(ST_HOLD));
    Start = 1'b0;
    step();
    check("hold_to_idle", 32'(dbg_state), 32'(ST_IDLE));
    check_all("idle_again");

    // Saturation: bird beyond every pipe scores each cycle.
    Bird_X = 10'd1023;
    start_run();
    for (int n = 1; n <= 20; n++) begin
      step();
      check("sat_score", 32'(Score), 32'((n < 15) ? n : 15));
      check("sat_pulse", 32'(Score_Pulse), 1);
      check("sat_index", 32'(Pipe_Index), 32'(n % 4));
      check_all("sat");
    end
    Freeze = 1'b1; step(); Freeze = 1'b0; step(); step();
    check("sat_idle", 32'(dbg_state), 32'(ST_IDLE));

    // Reset mid-RUN with Score = 7.
    Bird_X = 10'd0;
    start_run();
    Bird_X = 10'd1023;
    repeat (7) step();
    Bird_X = 10'd0;
    step();
    check("pre_reset_score", 32'(Score), 7);
    #2;
    reset = 1'b0;
    #1;
    check("async_running", 32'(Running), 0);
    check("async_score", 32'(Score), 0);
    check("async_index", 32'(Pipe_Index), 0);
    check("async_x_edge", 32'(X_Edge), 0);
    check("async_rd_x", 32'(Rd_X), 0);
    check("async_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge Clk);
    @(negedge Clk);
    reset = 1'b1;
    step();
    step();
    // lfsr restarted from A5: the new load must follow the model again.
    start_run();
    for (int i = 0; i < 4; i++) begin
      Rd_Index = 2'(i);
      #1;
      check("reload_y", 32'(Rd_Y), 32'(m_y[i]));
    end
    check_all("after_reset_run");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_scheduler.md
PIPE_SCHEDULER -- requirements
Module: pipe_scheduler

Interface
REQ-001 Parameter NUM_PIPES, 4, pipe slots in the ring; the value is a power of two.
REQ-002 Parameter SPACING, 10'd160, horizontal distance between consecutive pipes.
REQ-003 Parameter PIPE_W, 10'd80, pipe width; the right edge is X+PIPE_W.
REQ-004 Parameter SPEED, 10'd2, pixels scrolled per Tick.
REQ-005 Clk  input  1  single clock; all logic is on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 Start  input  1  level; begins a run from IDLE.
REQ-008 Tick  input  1  one-cycle frame strobe; scrolls the pipes.
REQ-009 Freeze  input  1  level from the collision logic (lose); halts scrolling.
REQ-010 Bird_X  input  10  bird left x.
REQ-011 Rd_Index  input  log2(NUM_PIPES)  display read-port slot select.
REQ-012 Pipe_Index  output  log2(NUM_PIPES)  slot currently in scope for collision.
REQ-013 X_Edge / Y_Edge  output  10 each  left edge and gap-top edge of the in-scope pipe.
REQ-014 Rd_X / Rd_Y  output  10 each  edges of slot Rd_Index; combinational read.
REQ-015 Score  output  4  pipes passed, saturating.
REQ-016 Score_Pulse  output  1  one-cycle strobe on each score increment.
REQ-017 Running  output  1  high in RUN.

Function
REQ-018 FSM states: IDLE, LOAD, RUN, HOLD.
- IDLE→LOAD on Start.
- LOAD→RUN after NUM_PIPES cycles.
- RUN→HOLD on Freeze.
- HOLD→IDLE when Freeze and Start are both low.
REQ-019 LOAD writes one slot per cycle, slot i = 0..N-1:
- X = 320 + i*SPACING.
- Y = 40 + {2'b0, lfsr[7:0]} (range 40..295).
- Score clears to 0 and Pipe_Index clears to 0 on entry to LOAD.
REQ-020 lfsr is 8 bits, taps x^8+x^6+x^5+x^4+1, advances every cycle, and is never zero.
REQ-021 In RUN, on Tick with Freeze low, every slot's X decreases by the effective speed in the same cycle.
REQ-022 Respawn: a slot whose X is less than the effective speed at a Tick gets:
- X = X(slot-1 mod N) + SPACING, using the pre-Tick value.
- a new Y from lfsr.
REQ-023 Scoring: in RUN, when X_Edge + PIPE_W < Bird_X, the following happen in one cycle:
- Score increments, saturating at 15.
- Score_Pulse asserts.
- Pipe_Index advances mod NUM_PIPES.
- At most one score event per cycle.
REQ-024 Score events are evaluated every cycle in RUN, not only on Tick, and are inhibited when Freeze is high.
REQ-025 Freeze and Tick in the same cycle: Freeze wins, no scroll occurs, and the FSM enters HOLD.
REQ-026 Start in LOAD, RUN or HOLD is ignored; Tick outside RUN is ignored.
REQ-027 In HOLD, pipe positions and Score are held so the display shows the frozen frame.
REQ-028 Register widths are 10 bits; edge sums are computed at 11 bits to avoid wrap in comparisons.

Reset
REQ-029 On reset low, at any time including mid-LOAD or mid-RUN:
- state = IDLE.
- Score = 0, Score_Pulse = 0, Running = 0, Pipe_Index = 0.
- All slot X = 0 and Y = 0.
- lfsr = 8'hA5.
REQ-030 Release of reset is synchronized internally; the first active edge is the second Clk after deassertion.

Configuration
REQ-031 Macro PIPE_SPEEDUP_EN defined: effective speed = SPEED + Score[3:2], so speed increases every 4 points.
REQ-032 Macro PIPE_SPEEDUP_EN undefined: effective speed = SPEED constant; no adder logic is present.

Structure
REQ-033 Package flappy_pkg holds:
- the FSM state encoding.
- the LFSR seed 8'hA5.
- the screen constants 640x480.
- the Y base 40 and gap height 100, shared with the collision and display blocks.
REQ-034 One sub-module pipe_lfsr (8-bit Galois LFSR with seed load) is instantiated once; the slot ring stays inline.

Verification
REQ-035 Start=1 for one cycle from IDLE → LOAD lasts 4 cycles; slot X values = 320/480/640/800; Running rises on cycle 6.
REQ-036 RUN, 160 Ticks with Bird_X = 500 → slot0 X = 0 then respawns at X(slot3)+160; Score increments once slot0 right edge < 500.
REQ-037 Force 20 pass events → Score stops at 15; Score_Pulse still pulses; Pipe_Index wraps 3→0.
REQ-038 Freeze and Tick in the same cycle → X values unchanged; HOLD entered; Score frozen; Freeze low → IDLE.
REQ-039 reset low mid-RUN with Score = 7 → all outputs 0 asynchronously; lfsr reloads A5.
REQ-040 With PIPE_SPEEDUP_EN and Score = 8 → each Tick reduces X by 4.
